ysyx_exu_seq: RTL and testbench

YSYX_EXU_SEQ -- requirements
Module: ysyx_exu_seq

---
 rtl/ysyx_exu_seq.sv | 128 ++++++++++++
 tb/tb_ysyx_exu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_exu_seq.sv
// Multi-cycle execute sequencer: steps one instruction through fetch, execute,
// optional LSU access and write-back, with a bus timeout and an ebreak halt.
module ysyx_exu_seq #(
  parameter logic [7:0]  TIMEOUT = 8'd255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_jump,
  input  logic             dec_ebreak,
  input  logic             dec_rf_wr_en,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  output logic             rf_wr_en,
  output logic             pc_wen,
  output logic             pc_sel,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_q;
  logic       store_q;
  logic       jump_q;
  logic       ebreak_q;
  logic       wr_q;

  // Wait budget runs out on this MEM_WAIT cycle.
  function automatic logic wait_expired();
    return 8'(wait_cnt + 8'd1) == TIMEOUT;
  endfunction

  function automatic state_t next_state();
    state_t nxt;
    nxt = state;
    case (state)
      FETCH:    if (ifu_valid) nxt = EXEC;
      EXEC: begin
        if (ebreak_q)                nxt = HALT;
        else if (load_q || store_q)  nxt = MEM_REQ;
        else                         nxt = WB;
      end
      MEM_REQ:  if (lsu_req_ready) nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (lsu_resp_valid)      nxt = WB;
        else if (wait_expired()) nxt = HALT;
      end
      WB:       nxt = FETCH;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
    return nxt;
  endfunction

  // Moore outputs {ifu_ready, lsu_req_valid, pc_wen, pc_sel, rf_wr_en, halted}.
  function automatic logic [5:0] moore_out(input state_t s);
    logic [5:0] o;
    o = 6'b000000;
    case (s)
      FETCH:   o[5] = 1'b1;
      MEM_REQ: o[4] = 1'b1;
      WB: begin
        o[3] = 1'b1;
        o[2] = jump_q;
        o[1] = wr_q & ~store_q;
      end
      HALT:    o[0] = 1'b1;
      default: o = 6'b000000;
    endcase
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      ifu_ready     <= 1'b1;
      lsu_req_valid <= 1'b0;
      pc_wen        <= 1'b0;
      pc_sel        <= 1'b0;
      rf_wr_en      <= 1'b0;
      halted        <= 1'b0;
      bus_err       <= 1'b0;
      retire_cnt    <= '0;
      wait_cnt      <= 8'd0;
      load_q        <= 1'b0;
      store_q       <= 1'b0;
      jump_q        <= 1'b0;
      ebreak_q      <= 1'b0;
      wr_q          <= 1'b0;
    end else begin
      state <= next_state();
      {ifu_ready, lsu_req_valid, pc_wen, pc_sel, rf_wr_en, halted} <= moore_out(next_state());

      if (state == FETCH && ifu_valid) begin
        load_q   <= dec_load;
        store_q  <= dec_store;
        jump_q   <= dec_jump;
        ebreak_q <= dec_ebreak;
        wr_q     <= dec_rf_wr_en;
      end

      if (state == MEM_REQ && lsu_req_ready) wait_cnt <= 8'd0;
      if (state == MEM_WAIT) wait_cnt <= 8'(wait_cnt + 8'd1);

      // A response on the final budget cycle still wins over the timeout.
      if (state == MEM_WAIT && !lsu_resp_valid && wait_expired()) bus_err <= 1'b1;

      if (state == WB) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_exu_seq.sv
// Directed bench for ysyx_exu_seq; write-back strobes are scored against a queue
// of expected {pc_sel, rf_wr_en} pushed when each instruction is issued.
module tb_ysyx_exu_seq;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifu_valid;
  logic             ifu_ready;
  logic             dec_load, dec_store, dec_jump, dec_ebreak, dec_rf_wr_en;
  logic             lsu_req_valid;
  logic             lsu_req_ready;
  logic             lsu_resp_valid;
  logic             rf_wr_en, pc_wen, pc_sel, halted, bus_err;
  logic [CNT_W-1:0] retire_cnt;

  typedef struct packed {
    logic sel;
    logic wr;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] model_cnt;
  int               checks = 0;
  int               errors = 0;

  ysyx_exu_seq #(.TIMEOUT(8'd255), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .dec_load(dec_load), .dec_store(dec_store), .dec_jump(dec_jump),
    .dec_ebreak(dec_ebreak), .dec_rf_wr_en(dec_rf_wr_en),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid),
    .rf_wr_en(rf_wr_en), .pc_wen(pc_wen), .pc_sel(pc_sel),
    .halted(halted), .bus_err(bus_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write-back strobe must match the oldest issued instruction.
  always @(negedge clk) begin
    if (!rst && rf_wr_en) check("rf_without_pc_wen", 32'(pc_wen), 32'd1);
    if (!rst && pc_wen) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wb_pc_sel", 32'(pc_sel), 32'(e.sel));
        check("wb_rf_wr_en", 32'(rf_wr_en), 32'(e.wr));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ifu_ready"}, 32'(ifu_ready), 32'd1);
    check({tag, "_lsu_req_valid"}, 32'(lsu_req_valid), 32'd0);
    check({tag, "_rf_wr_en"}, 32'(rf_wr_en), 32'd0);
    check({tag, "_pc_wen"}, 32'(pc_wen), 32'd0);
    check({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check({tag, "_retire_cnt"}, 32'(retire_cnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    model_cnt = '0;
    check_reset(tag);
  endtask

  // Accept one instruction, then scramble the decode inputs (they must be ignored).
  task automatic issue(input logic ld, input logic st, input logic jmp, input logic brk, input logic wr);
    check("fetch_ready", 32'(ifu_ready), 32'd1);
    ifu_valid = 1'b1;
    {dec_load, dec_store, dec_jump, dec_ebreak, dec_rf_wr_en} = {ld, st, jmp, brk, wr};
    tick();
    if (!brk) sb.push_back('{sel: jmp, wr: wr & ~st});
    {dec_load, dec_store, dec_jump, dec_ebreak, dec_rf_wr_en} = 5'($urandom);
  endtask

  task automatic run_op(input logic jmp, input logic wr);
    issue(1'b0, 1'b0, jmp, 1'b0, wr);
    check("exec_pc_wen", 32'(pc_wen), 32'd0);
    check("exec_ifu_ready", 32'(ifu_ready), 32'd0);
    tick();
    check("wb_pc_wen_at_2", 32'(pc_wen), 32'd1);
    check("wb_cnt_before", 32'(retire_cnt), 32'(model_cnt));
    tick();
    ifu_valid = 1'b0;
    model_cnt = model_cnt + 1'b1;
    check("retire_cnt", 32'(retire_cnt), 32'(model_cnt));
    check("fetch_pc_wen", 32'(pc_wen), 32'd0);
  endtask

  // resp_cyc: MEM_WAIT cycle (1-based) carrying the response, 0 for none.
  task automatic mem_op(input logic ld, input logic st, input logic wr,
                        input int req_delay, input int resp_cyc);
    issue(ld, st, 1'b0, 1'b0, wr);
    ifu_valid = 1'b1;
    lsu_resp_valid = 1'b1;
    tick();
    for (int i = 0; i <= req_delay; i++) begin
      check("req_valid_held", 32'(lsu_req_valid), 32'd1);
      lsu_req_ready = (i == req_delay);
      tick();
    end
    lsu_req_ready = 1'b0;
    lsu_resp_valid = 1'b0;
    check("wait_req_dropped", 32'(lsu_req_valid), 32'd0);
    for (int c = 1; c <= int'(TMO); c++) begin
      if (c == int'(TMO)) check("last_wait_no_err", 32'(bus_err), 32'd0);
      lsu_resp_valid = (c == resp_cyc);
      tick();
      if (lsu_resp_valid) begin
        lsu_resp_valid = 1'b0;
        break;
      end
    end
    lsu_resp_valid = 1'b0;
    if (resp_cyc >= 1 && resp_cyc <= int'(TMO)) begin
      check("mem_wb_pc_wen", 32'(pc_wen), 32'd1);
      tick();
      ifu_valid = 1'b0;
      model_cnt = model_cnt + 1'b1;
      check("mem_retire_cnt", 32'(retire_cnt), 32'(model_cnt));
      check("mem_bus_err", 32'(bus_err), 32'd0);
    end else begin
      ifu_valid = 1'b0;
      void'(sb.pop_back());
      check("tmo_bus_err", 32'(bus_err), 32'd1);
      check("tmo_halted", 32'(halted), 32'd1);
      check("tmo_ifu_ready", 32'(ifu_ready), 32'd0);
      check("tmo_retire_cnt", 32'(retire_cnt), 32'(model_cnt));
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_valid = 1'b0;
    {dec_load, dec_store, dec_jump, dec_ebreak, dec_rf_wr_en} = 5'd0;
    lsu_req_ready = 1'b0;
    lsu_resp_valid = 1'b0;
    tick();
    do_reset("reset");

    run_op(1'b0, 1'b1);
    run_op(1'b1, 1'b1);
    run_op(1'b0, 1'b0);
    mem_op(1'b0, 1'b1, 1'b1, 3, 2);
    mem_op(1'b1, 1'b0, 1'b1, 0, 1);
    mem_op(1'b1, 1'b0, 1'b1, 1, int'(TMO));
    mem_op(1'b1, 1'b0, 1'b1, 0, 0);

    // Halted: new instructions and LSU responses are ignored.
    ifu_valid = 1'b1;
    {dec_load, dec_store, dec_jump, dec_ebreak, dec_rf_wr_en} = 5'b00001;
    lsu_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_ifu_ready", 32'(ifu_ready), 32'd0);
      check("halt_sticky", 32'({halted, bus_err}), 32'd3);
      check("halt_cnt_frozen", 32'(retire_cnt), 32'(model_cnt));
    end
    lsu_resp_valid = 1'b0;
    ifu_valid = 1'b0;
    do_reset("rst_in_halt");

    // Reset mid-MEM_WAIT, with a response and a fetch competing on the same edge.
    run_op(1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ifu_valid = 1'b0;
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    lsu_resp_valid = 1'b1;
    ifu_valid = 1'b1;
    tick();
    rst = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_valid = 1'b0;
    sb.delete();
    model_cnt = '0;
    check_reset("rst_in_wait");
    tick();
    check("post_rst_fetch", 32'({ifu_ready, pc_wen}), 32'b10);

    // ebreak halts without retiring.
    run_op(1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ifu_valid = 1'b1;
    tick();
    check("ebreak_halted", 32'(halted), 32'd1);
    check("ebreak_no_bus_err", 32'(bus_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ebreak_cnt_frozen", 32'(retire_cnt), 32'(model_cnt));
      check("ebreak_ifu_ready", 32'(ifu_ready), 32'd0);
    end
    ifu_valid = 1'b0;
    do_reset("rst_after_ebreak");

    // Counter wrap.
    for (int i = 0; i < (1 << CNT_W) - 1; i++) run_op(1'(i), 1'(i >> 1));
    check("cnt_at_max", 32'(retire_cnt), 32'((1 << CNT_W) - 1));
    run_op(1'b0, 1'b1);
    check("cnt_wrapped", 32'(retire_cnt), 32'd0);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
